// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the load/store unit and the byte-addressable data memory.
// The master drives requests and consumes responses; the slave is the memory.
interface data_mem_lsu_if #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [1:0]              req_size;
    logic                    req_signed;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [BYTE_SIZE*8-1:0]  req_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [BYTE_SIZE*8-1:0]  rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with ready/valid request and response channels,
// registered load data with sign/zero extension, and error responses for bad accesses.
module data_mem_lsu #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_lsu_if.slave  bus
);
    localparam int DW    = BYTE_SIZE * 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW1   = ADDR_WIDTH + 1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t state_reg, state_next;

    logic [7:0]       mem [DEPTH];

    logic [3:0]       n_bytes;
    logic             size_err;
    logic             misalign_err;
    logic             range_err;
    logic             req_err;
    logic [AW1-1:0]   end_addr;
    logic             req_ready_int;
    logic             accept;
    logic [IDX_W-1:0] base_idx;
    logic             sign_bit;
    logic             fill_bit;

    logic [BYTE_SIZE-1:0] lane_en;
    logic [IDX_W-1:0]     lane_idx [BYTE_SIZE];
    logic [7:0]           rd_byte  [BYTE_SIZE];
    logic [DW-1:0]        load_ext;

    logic [DW-1:0]    rsp_rdata_reg;
    logic             rsp_err_reg;

    // Request decode and fault classification
    assign n_bytes      = 4'd1 << bus.req_size;
    assign size_err     = (bus.req_size == 2'b11) && (BYTE_SIZE == 4);
    // n_bytes-1 in three bits gives the alignment mask for 1/2/4/8 byte accesses
    assign misalign_err = (bus.req_addr[2:0] & (n_bytes[2:0] - 3'd1)) != 3'd0;
    assign end_addr     = {1'b0, bus.req_addr} + AW1'(n_bytes);
    assign range_err    = end_addr > AW1'(DEPTH);
    assign req_err      = size_err | misalign_err | range_err;

    // Ready is held low while in reset so nothing is accepted until rst deasserts
    assign req_ready_int = !rst && ((state_reg == IDLE) || bus.rsp_ready);
    assign accept        = bus.req_valid && req_ready_int;
    assign base_idx      = bus.req_addr[IDX_W-1:0];

    generate
        for (genvar gi = 0; gi < BYTE_SIZE; gi++) begin : g_lane
            assign lane_en[gi]         = 4'(gi) < n_bytes;
            assign lane_idx[gi]        = base_idx + IDX_W'(gi);
            assign rd_byte[gi]         = mem[lane_idx[gi]];
            assign load_ext[8*gi +: 8] = lane_en[gi] ? rd_byte[gi] : {8{fill_bit}};
        end
    endgenerate

    always_comb begin
        sign_bit = 1'b0;
        case (bus.req_size)
            2'b00:   sign_bit = rd_byte[0][7];
            2'b01:   sign_bit = rd_byte[1][7];
            2'b10:   sign_bit = rd_byte[3][7];
            default: sign_bit = rd_byte[BYTE_SIZE-1][7];
        endcase
    end

    assign fill_bit = bus.req_signed & sign_bit;

    // Storage is deliberately left out of reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
            for (int k = 0; k < BYTE_SIZE; k++) begin
                if (lane_en[k]) begin
                    mem[lane_idx[k]] <= bus.req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else if (accept) begin
            rsp_err_reg   <= req_err;
            rsp_rdata_reg <= (req_err || bus.req_we) ? '0 : load_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bus.rsp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                // A same-cycle accept replaces the consumed response without a bubble
                if (bus.rsp_ready && !accept) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_int;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: a 4-byte and an 8-byte instance share one stimulus
// driver, with use8 selecting which instance receives requests and is observed.
module tb_data_mem_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        use8 = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        rsp_ready = 1'b1;

    logic        o_valid, o_ready, o_err;
    logic [63:0] o_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_lsu_if #(.BYTE_SIZE(4), .ADDR_WIDTH(32)) if4 ();
    data_mem_lsu_if #(.BYTE_SIZE(8), .ADDR_WIDTH(32)) if8 ();

    assign if4.req_valid  = req_valid & ~use8;
    assign if4.req_we     = req_we;
    assign if4.req_size   = req_size;
    assign if4.req_signed = req_signed;
    assign if4.req_addr   = req_addr;
    assign if4.req_wdata  = req_wdata[31:0];
    assign if4.rsp_ready  = rsp_ready;

    assign if8.req_valid  = req_valid & use8;
    assign if8.req_we     = req_we;
    assign if8.req_size   = req_size;
    assign if8.req_signed = req_signed;
    assign if8.req_addr   = req_addr;
    assign if8.req_wdata  = req_wdata;
    assign if8.rsp_ready  = rsp_ready;

    assign o_valid = use8 ? if8.rsp_valid : if4.rsp_valid;
    assign o_ready = use8 ? if8.req_ready : if4.req_ready;
    assign o_err   = use8 ? if8.rsp_err   : if4.rsp_err;
    assign o_rdata = use8 ? if8.rsp_rdata : {32'h0, if4.rsp_rdata};

    data_mem_lsu #(.BYTE_SIZE(4), .ADDR_WIDTH(32), .DEPTH(1024)) dut4 (
        .clk(clk), .rst(rst), .bus(if4)
    );

    data_mem_lsu #(.BYTE_SIZE(8), .ADDR_WIDTH(32), .DEPTH(1024)) dut8 (
        .clk(clk), .rst(rst), .bus(if8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One accepted request with rsp_ready held high; response checked just after the edge
    task automatic txn(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        chk({tag, "/ready"}, 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        $display("txn %-10s we=%0b size=%0d addr=%h rdata=%h err=%0b",
                 tag, we, size, addr, o_rdata, o_err);
        chk({tag, "/valid"}, 64'(o_valid), 64'd1);
        chk({tag, "/rdata"}, o_rdata, exp_rd);
        chk({tag, "/err"},   64'(o_err), 64'(exp_err));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst/valid", 64'(o_valid), 64'd0);
        chk("rst/rdata", o_rdata, 64'd0);
        chk("rst/err",   64'(o_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst/ready", 64'(o_ready), 64'd1);

        // 4-byte instance: round trip, extension, errors
        txn("st_w10",  1, 2'b10, 0, 32'h10,  64'hDEADBEEF, 64'h0, 0);
        txn("ld_w10",  0, 2'b10, 0, 32'h10,  64'h0, 64'hDEADBEEF, 0);
        txn("ld_w10s", 0, 2'b10, 1, 32'h10,  64'h0, 64'hDEADBEEF, 0);
        txn("st_b20",  1, 2'b00, 0, 32'h20,  64'hAAAAAAEF, 64'h0, 0);
        txn("st_b21",  1, 2'b00, 0, 32'h21,  64'h55555580, 64'h0, 0);
        txn("ld_b21s", 0, 2'b00, 1, 32'h21,  64'h0, 64'hFFFFFF80, 0);
        txn("ld_b21u", 0, 2'b00, 0, 32'h21,  64'h0, 64'h00000080, 0);
        txn("ld_h20s", 0, 2'b01, 1, 32'h20,  64'h0, 64'hFFFF80EF, 0);
        txn("ld_h20u", 0, 2'b01, 0, 32'h20,  64'h0, 64'h000080EF, 0);
        txn("ld_w02",  0, 2'b10, 0, 32'h02,  64'h0, 64'h0, 1);
        txn("st_b3ff", 1, 2'b00, 0, 32'h3FF, 64'h5A, 64'h0, 0);
        txn("st_h3ff", 1, 2'b01, 0, 32'h3FF, 64'hBBBB, 64'h0, 1);
        txn("ld_b3ff", 0, 2'b00, 0, 32'h3FF, 64'h0, 64'h5A, 0);
        txn("st_w400", 1, 2'b10, 0, 32'h400, 64'h12345678, 64'h0, 1);
        txn("ld_d08",  0, 2'b11, 0, 32'h08,  64'h0, 64'h0, 1);
        txn("st_h3fe", 1, 2'b01, 0, 32'h3FE, 64'h1234, 64'h0, 0);
        txn("ld_b3ffb",0, 2'b00, 0, 32'h3FF, 64'h0, 64'h12, 0);
        txn("st_w54",  1, 2'b10, 0, 32'h54,  64'h0, 64'h0, 0);

        // Backpressure: load held for 3 cycles while a different store waits
        idle_cycle();
        @(negedge clk);
        req_we = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h10;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_we = 1; req_addr = 32'h54; req_wdata = 64'h99999999;
        for (int i = 0; i < 3; i++) begin
            chk("bp/valid", 64'(o_valid), 64'd1);
            chk("bp/rdata", o_rdata, 64'hDEADBEEF);
            chk("bp/err",   64'(o_err), 64'd0);
            chk("bp/ready", 64'(o_ready), 64'd0);
            $display("txn bp_hold%0d rdata=%h ready=%0b", i, o_rdata, o_ready);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        req_addr = 32'h50; req_wdata = 64'h5555AAAA; rsp_ready = 1'b1;
        #1;
        chk("bp/release_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        $display("txn bp_st50 rdata=%h err=%0b", o_rdata, o_err);
        chk("bp/st_valid", 64'(o_valid), 64'd1);
        chk("bp/st_rdata", o_rdata, 64'h0);
        txn("ld_w54",  0, 2'b10, 0, 32'h54, 64'h0, 64'h0, 0);
        txn("ld_w50",  0, 2'b10, 0, 32'h50, 64'h0, 64'h5555AAAA, 0);

        // Reset while a response is pending
        txn("st_w40",  1, 2'b10, 0, 32'h40, 64'h11223344, 64'h0, 0);
        idle_cycle();
        @(negedge clk);
        req_we = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h40;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("mid/valid_before", 64'(o_valid), 64'd1);
        chk("mid/rdata_before", o_rdata, 64'h11223344);
        #2;
        rst = 1'b1;
        #1;
        $display("txn mid_rst valid=%0b rdata=%h", o_valid, o_rdata);
        chk("mid/valid_in_rst", 64'(o_valid), 64'd0);
        chk("mid/rdata_in_rst", o_rdata, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("mid/ready_after", 64'(o_ready), 64'd1);
        chk("mid/valid_after", 64'(o_valid), 64'd0);
        txn("ld_w40",  0, 2'b10, 0, 32'h40, 64'h0, 64'h11223344, 0);

        // 8-byte instance: streaming store/load pairs, one per cycle
        idle_cycle();
        use8 = 1'b1;
        txn("s_d00",  1, 2'b11, 0, 32'h00,  64'h0123456789ABCDEF, 64'h0, 0);
        txn("l_d00",  0, 2'b11, 0, 32'h00,  64'h0, 64'h0123456789ABCDEF, 0);
        txn("s_w08",  1, 2'b10, 0, 32'h08,  64'hFFFFFFFF87654321, 64'h0, 0);
        txn("l_w08s", 0, 2'b10, 1, 32'h08,  64'h0, 64'hFFFFFFFF87654321, 0);
        txn("s_w0c",  1, 2'b10, 0, 32'h0C,  64'h1111111112345678, 64'h0, 0);
        txn("l_w0cu", 0, 2'b10, 0, 32'h0C,  64'h0, 64'h0000000012345678, 0);
        txn("s_h10",  1, 2'b01, 0, 32'h10,  64'h000000000000F00D, 64'h0, 0);
        txn("l_h10s", 0, 2'b01, 1, 32'h10,  64'h0, 64'hFFFFFFFFFFFFF00D, 0);
        txn("s_b13",  1, 2'b00, 0, 32'h13,  64'h000000000000007F, 64'h0, 0);
        txn("l_b13s", 0, 2'b00, 1, 32'h13,  64'h0, 64'h000000000000007F, 0);
        txn("s_d3f8", 1, 2'b11, 0, 32'h3F8, 64'hCAFEF00DDEADBEEF, 64'h0, 0);
        txn("l_d3f8", 0, 2'b11, 0, 32'h3F8, 64'h0, 64'hCAFEF00DDEADBEEF, 0);
        txn("s_b18",  1, 2'b00, 0, 32'h18,  64'h00000000000000C3, 64'h0, 0);
        txn("l_b18u", 0, 2'b00, 0, 32'h18,  64'h0, 64'h00000000000000C3, 0);
        txn("s_d20",  1, 2'b11, 0, 32'h20,  64'h8000000000000001, 64'h0, 0);
        txn("l_d20s", 0, 2'b11, 1, 32'h20,  64'h0, 64'h8000000000000001, 0);
        txn("l_d04",  0, 2'b11, 0, 32'h04,  64'h0, 64'h0, 1);
        txn("l_d400", 0, 2'b11, 0, 32'h400, 64'h0, 64'h0, 1);
        txn("l_w0c",  0, 2'b10, 0, 32'h0C,  64'h0, 64'h0000000012345678, 0);

        idle_cycle();
        chk("end/valid", 64'(o_valid), 64'd0);
        chk("end/ready", 64'(o_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Byte-addressable data memory with a request/response handshake, the next-generation data-side memory of the single-cycle RISC-V core, placed between the load/store unit and the UART/peripheral decode. Generalised in data width (4 or 8 bytes) and depth. Supports byte, half, word and (when 8-byte) double accesses with signed or unsigned load extension. Adds features the previous memory lacks: registered read data, ready/valid backpressure, and error responses for misaligned, out-of-range or illegal-size accesses.

## Interface
- BYTE_SIZE, 4, bytes per data word; legal values 4 or 8
- ADDR_WIDTH, 32, request address width
- DEPTH, 1024, memory size in bytes; power of two, at least BYTE_SIZE
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 double
- req_signed  in  1  load sign-extension enable; ignored for stores
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  BYTE_SIZE*8  store data, little-endian, low bytes used
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge
- rsp_rdata  out  BYTE_SIZE*8  load data; 0 for stores and errors
- rsp_err  out  1  access faulted; no memory state changed

## Operation
- Storage: DEPTH bytes. Contents are not cleared by reset.
- Access width: N = 1, 2, 4 or 8 bytes for size 00/01/10/11.
- Error conditions, evaluated at acceptance:
  - size 11 when BYTE_SIZE=4;
  - req_addr not a multiple of N;
  - req_addr + N > DEPTH.
- An erroring request performs no write and returns rsp_err=1, rsp_rdata=0.
- Store: bytes req_wdata[8k+:8] are written to mem[addr+k] for k < N at the accepting edge. Bytes outside the access are untouched. The response carries rsp_err=0 and rsp_rdata=0.
- Load:
  - rsp_rdata[8k+:8] = mem[addr+k] for k < N, registered at the accepting edge.
  - Upper bits are zero-filled, or filled with bit 8N-1 of the loaded data when req_signed=1.
  - For N = BYTE_SIZE, req_signed has no effect.
- State machine, two states:
  - IDLE: rsp_valid=0, req_ready=1. On accept, go to RESP.
  - RESP: rsp_valid=1 and the response is held stable. On rsp_ready with no new accept, go to IDLE. On rsp_ready with a new accept in the same cycle, stay in RESP with the new response. Without rsp_ready, stay in RESP.
- req_ready = (state==IDLE) || rsp_ready. The ready path combinationally includes rsp_ready.
- Only one outstanding request is allowed. Load data always reflects all previously accepted stores.

## Timing
- Reset (asynchronous, in any state): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 once rst deasserts.
- Reset mid-response: a pending response is discarded. A store already accepted stays written.
- Latency: request accepted at edge E; rsp_valid=1 from just after E. Earliest consumption is at edge E+1.
- Throughput: one access per cycle when rsp_ready is held at 1.
- Back-to-back store then load to the same address: the load accepted at E+1 returns the data stored at E.
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_rdata, rsp_err and req_ready=0 are held. No request is accepted.
- Requests with req_valid=0 have no effect; request inputs are don't-care.

## Test plan
- Reset mid-response: load accepted, rst pulsed before rsp_ready -> rsp_valid=0 immediately. A subsequent load of that address returns the previously stored data.
- Word round-trip: store word 0xDEADBEEF at 0x10, then load word from 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
- Extension:
  - store byte 0x80 at 0x21, load byte signed -> 0xFFFFFF80; unsigned -> 0x00000080;
  - load half signed at 0x20 -> 0xFFFF80EF, given byte 0x20 = 0xEF.
- Errors:
  - load word at 0x02 -> rsp_err=1, rdata=0;
  - store half at DEPTH-1 -> rsp_err=1, memory unchanged;
  - size 11 with BYTE_SIZE=4 -> rsp_err=1.
- Backpressure: rsp_ready=0 for 3 cycles after a load -> response stable and req_ready=0 throughout. Raising rsp_ready with req_valid=1 accepts the next request in the same edge.
- Streaming: rsp_ready=1, 8 alternating store/load pairs on consecutive cycles (BYTE_SIZE=8, double accesses included) -> one response per cycle, each load matching its preceding store.
